// File: rtl/mem_load_store_unit.sv
// mem_load_store_unit
//    MEM-stage access controller sitting between the EX/MEM pipeline register and a
//    byte-addressed, big-endian data memory. A request is checked for alignment and then
//    turned into a word-addressed bus access. Byte enables and lane-replicated store data
//    are built here. Load data is lane-selected and sign- or zero-extended. The pipeline
//    is stalled (req_ready=0) from acceptance until the one-cycle response pulse has been
//    given. A misaligned or reserved-size access, or a memory that does not acknowledge
//    within ACK_TIMEOUT cycles, is reported with resp_error.
//
// Parameters
//    ACK_TIMEOUT   WAIT cycles without mem_ack before a bus error (0 = wait forever)
//
// Ports
//    clk, reset                      clock, synchronous active-high reset
//    req_valid/write/size/unsigned   request from EX/MEM (size: 00 word, 01 half, 10 byte)
//    req_addr, req_wdata             byte address, right-justified store data
//    req_ready                       request accepted this cycle / pipeline stall when 0
//    mem_req/we/addr/be/wdata        memory request, held until mem_ack
//    mem_ack, mem_rdata              memory completion and big-endian read word
//    resp_valid/data/error           one-cycle completion pulse with extended load data

module mem_load_store_unit #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_error
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
   // Last WAIT cycle count value before the timeout fires.
   localparam logic [CNT_W-1:0] CNT_LAST = (ACK_TIMEOUT > 0) ? CNT_W'(ACK_TIMEOUT - 1) : '0;

   logic [1:0]       state_reg;
   logic             mem_req_reg;
   logic             mem_we_reg;
   logic [31:0]      mem_addr_reg;
   logic [3:0]       mem_be_reg;
   logic [31:0]      mem_wdata_reg;
   logic [31:0]      resp_data_reg;
   logic             resp_error_reg;
   logic [CNT_W-1:0] tmo_cnt_reg;

   // Request fields needed after acceptance to pick and extend the load data.
   logic [1:0]       lat_size_reg;
   logic [1:0]       lat_off_reg;
   logic             lat_unsigned_reg;
   logic             lat_write_reg;

   // ------------------------------------------------------------------
   // Request decode (only meaningful in IDLE, where it is sampled)
   // ------------------------------------------------------------------
   logic [1:0]  req_off;
   logic [3:0]  byte_be;
   logic        req_bad;
   logic [3:0]  req_be;
   logic [31:0] req_lane_wdata;

   assign req_off = req_addr[1:0];

   // be[3] is offset 0 (bits [31:24]), so a byte at offset gi enables bit 3-gi.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_byte_be
         assign byte_be[3-gi] = (req_off == 2'(gi));
      end
   endgenerate

   always_comb begin
      req_bad        = 1'b0;
      req_be         = 4'b0000;
      req_lane_wdata = '0;
      case (req_size)
         SZ_WORD: begin
            req_bad        = (req_off != 2'b00);
            req_be         = 4'b1111;
            req_lane_wdata = req_wdata;
         end
         SZ_HALF: begin
            req_bad        = req_off[0];
            req_be         = req_off[1] ? 4'b0011 : 4'b1100;
            req_lane_wdata = {2{req_wdata[15:0]}};
         end
         SZ_BYTE: begin
            req_be         = byte_be;
            req_lane_wdata = {4{req_wdata[7:0]}};
         end
         default: req_bad = 1'b1;
      endcase
      if (!req_write) begin
         req_lane_wdata = '0;
      end
   end

   // ------------------------------------------------------------------
   // Load lane select and extension from the acknowledged read word
   // ------------------------------------------------------------------
   logic [7:0]  rd_byte [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;

   // Big-endian: offset 0 is the most significant byte of the word.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_rd_byte
         assign rd_byte[gi] = mem_rdata[31-8*gi -: 8];
      end
   endgenerate

   always_comb begin
      byte_sel  = rd_byte[lat_off_reg];
      half_sel  = lat_off_reg[1] ? mem_rdata[15:0] : mem_rdata[31:16];
      load_data = '0;
      case (lat_size_reg)
         SZ_WORD: load_data = mem_rdata;
         SZ_HALF: load_data = {{16{half_sel[15] & ~lat_unsigned_reg}}, half_sel};
         SZ_BYTE: load_data = {{24{byte_sel[7] & ~lat_unsigned_reg}}, byte_sel};
         default: load_data = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Access sequencer
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         mem_req_reg      <= 1'b0;
         mem_we_reg       <= 1'b0;
         mem_addr_reg     <= '0;
         mem_be_reg       <= '0;
         mem_wdata_reg    <= '0;
         resp_data_reg    <= '0;
         resp_error_reg   <= 1'b0;
         tmo_cnt_reg      <= '0;
         lat_size_reg     <= '0;
         lat_off_reg      <= '0;
         lat_unsigned_reg <= 1'b0;
         lat_write_reg    <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (req_valid) begin
                  lat_size_reg     <= req_size;
                  lat_off_reg      <= req_off;
                  lat_unsigned_reg <= req_unsigned;
                  lat_write_reg    <= req_write;
                  if (req_bad) begin
                     // Rejected without touching the bus; response in the next cycle.
                     resp_data_reg  <= '0;
                     resp_error_reg <= 1'b1;
                     state_reg      <= ST_DONE;
                  end else begin
                     // Bus fields are registered here so they are valid in ISSUE.
                     mem_req_reg   <= 1'b1;
                     mem_we_reg    <= req_write;
                     mem_addr_reg  <= {req_addr[31:2], 2'b00};
                     mem_be_reg    <= req_be;
                     mem_wdata_reg <= req_lane_wdata;
                     state_reg     <= ST_ISSUE;
                  end
               end
            end

            ST_ISSUE: begin
               // An ack here is too early and is deliberately ignored.
               tmo_cnt_reg <= '0;
               state_reg   <= ST_WAIT;
            end

            ST_WAIT: begin
               if (mem_ack) begin
                  resp_data_reg  <= lat_write_reg ? 32'd0 : load_data;
                  resp_error_reg <= 1'b0;
                  mem_req_reg    <= 1'b0;
                  mem_we_reg     <= 1'b0;
                  tmo_cnt_reg    <= '0;
                  state_reg      <= ST_DONE;
               end else if ((ACK_TIMEOUT != 0) && (tmo_cnt_reg == CNT_LAST)) begin
                  resp_data_reg  <= '0;
                  resp_error_reg <= 1'b1;
                  mem_req_reg    <= 1'b0;
                  mem_we_reg     <= 1'b0;
                  tmo_cnt_reg    <= '0;
                  state_reg      <= ST_DONE;
               end else if (ACK_TIMEOUT != 0) begin
                  tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
               end
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = (state_reg == ST_IDLE);
   assign resp_valid = (state_reg == ST_DONE);
   assign mem_req    = mem_req_reg;
   assign mem_we     = mem_we_reg;
   assign mem_addr   = mem_addr_reg;
   assign mem_be     = mem_be_reg;
   assign mem_wdata  = mem_wdata_reg;
   assign resp_data  = resp_data_reg;
   assign resp_error = resp_error_reg;

endmodule

// File: tb/tb_mem_load_store_unit.sv
// tb_mem_load_store_unit
//    Scoreboard bench for mem_load_store_unit. The stimulus process computes each
//    expected bus request and response from a byte-level memory model and queues them;
//    a bus responder process acts as the memory and checks every request cycle; a
//    monitor process checks every response pulse against the queue.

module tb_mem_load_store_unit;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_error;

   always #5 clk = ~clk;

   mem_load_store_unit #(.ACK_TIMEOUT(TMO)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_ready    (req_ready),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_be       (mem_be),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .resp_error   (resp_error)
   );

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   resp_t       resp_q [$];
   bus_t        bus_q  [$];
   logic [31:0] ref_mem  [16];   // model view of memory
   logic [31:0] phys_mem [16];   // what the responder actually holds
   int          n_cmp = 0;
   int          n_err = 0;
   int          n_resp = 0;
   int          cyc = 0;
   int          ack_delay = 1;   // ack in WAIT cycle N (1 = first); 0 = never
   bit          spur = 1'b0;     // spurious ack during ISSUE
   bit          noise = 1'b1;    // random acks while no request is pending
   bit          late_ack = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h, required %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, ".req_ready"},  {31'd0, req_ready},  32'd1);
      chk({tag, ".mem_req"},    {31'd0, mem_req},    32'd0);
      chk({tag, ".mem_we"},     {31'd0, mem_we},     32'd0);
      chk({tag, ".mem_be"},     {28'd0, mem_be},     32'd0);
      chk({tag, ".mem_addr"},   mem_addr,            32'd0);
      chk({tag, ".mem_wdata"},  mem_wdata,           32'd0);
      chk({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, ".resp_data"},  resp_data,           32'd0);
      chk({tag, ".resp_error"}, {31'd0, resp_error}, 32'd0);
   endtask

   // Memory responder: acts one time unit after each rising edge.
   initial begin : responder
      int   cnt;
      int   idx;
      bus_t cur;
      logic [31:0] w;
      cnt = 0;
      cur = '{default: '0};
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (late_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = phys_mem[0];
            late_ack  = 1'b0;
            cnt       = 0;
         end else if (mem_req === 1'b1) begin
            if (cnt == 0) begin
               if (bus_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL bus_unexpected: got mem_req=1 addr=%08h, required no request", mem_addr);
                  cur.addr = mem_addr; cur.we = mem_we; cur.be = mem_be; cur.wdata = mem_wdata;
               end else begin
                  cur = bus_q.pop_front();
               end
            end
            chk("mem_addr",  mem_addr,          cur.addr);
            chk("mem_we",    {31'd0, mem_we},   {31'd0, cur.we});
            chk("mem_be",    {28'd0, mem_be},   {28'd0, cur.be});
            chk("mem_wdata", mem_wdata,         cur.wdata);
            if (cnt == 0 && spur) begin
               mem_ack = 1'b1;   // garbage data, must be ignored
            end else if (cnt != 0 && cnt == ack_delay) begin
               idx       = int'(mem_addr[5:2]);
               w         = phys_mem[idx];
               mem_ack   = 1'b1;
               mem_rdata = w;
               if (mem_we) begin
                  for (int i = 0; i < 4; i++) begin
                     if (mem_be[3-i]) w[31-8*i -: 8] = mem_wdata[31-8*i -: 8];
                  end
                  phys_mem[idx] = w;
               end
            end
            cnt++;
         end else begin
            cnt = 0;
            if (noise && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
         end
      end
   end

   // Response monitor.
   initial begin : monitor
      resp_t e;
      forever begin
         @(negedge clk);
         if (resp_valid === 1'b1) begin
            if (resp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL resp_unexpected: got resp_valid=1 data=%08h, required no response", resp_data);
            end else begin
               e = resp_q.pop_front();
               n_resp++;
               $display("resp %0d: data=%08h err=%0d cycle=%0d", n_resp, resp_data, resp_error, cyc);
               chk("resp_data",  resp_data,              e.data);
               chk("resp_error", {31'd0, resp_error},    {31'd0, e.err});
               chk("resp_cycle", cyc,                    e.cyc);
               chk("mem_req_in_done", {31'd0, mem_req},  32'd0);
            end
         end
      end
   end

   // Issue one request at the current falling edge and wait for the unit to idle.
   task automatic issue(input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int dly, input bit sp,
                        input bit use_exp, input logic [31:0] exp_data);
      int          off;
      int          idx;
      int          nb;
      int          lat;
      bit          err;
      bit          done;
      logic [7:0]  acc [4];
      logic [31:0] word;
      logic [31:0] val;
      resp_t       r;
      bus_t        b;
      off = int'(addr[1:0]);
      idx = int'(addr[5:2]);
      err = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b00 && off != 0);
      r.data = '0;
      r.err  = err;
      lat    = 1;
      if (!err) begin
         nb = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
         for (int k = 0; k < nb; k++) acc[k] = 8'(wd >> (8 * (nb - 1 - k)));
         b.addr  = {addr[31:2], 2'b00};
         b.we    = wr;
         b.be    = '0;
         b.wdata = '0;
         for (int k = 0; k < nb; k++) b.be[3-(off+k)] = 1'b1;
         for (int j = 0; j < 4; j++) b.wdata[31-8*j -: 8] = wr ? acc[j % nb] : 8'h00;
         bus_q.push_back(b);
         ack_delay = dly;
         spur      = sp;
         if (dly == 0) begin
            r.err = 1'b1;
            lat   = 2 + TMO;
         end else begin
            lat  = 2 + dly;
            word = ref_mem[idx];
            if (wr) begin
               for (int k = 0; k < nb; k++) word[31-8*(off+k) -: 8] = acc[k];
               ref_mem[idx] = word;
            end else begin
               val = '0;
               for (int k = 0; k < nb; k++) val = (val << 8) | ((word >> (8 * (3 - (off + k)))) & 32'hFF);
               if (!uns && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
               r.data = val;
            end
         end
      end
      if (use_exp) r.data = exp_data;
      r.cyc = cyc + lat;
      resp_q.push_back(r);

      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      @(negedge clk);
      chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
      req_valid    = 1'b0;
      req_write    = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
      done = 1'b0;
      for (int t = 0; t < 40 && !done; t++) begin
         if (resp_q.size() == 0 && req_ready === 1'b1) done = 1'b1;
         else @(negedge clk);
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL ready_timeout: got no idle within 40 cycles, required response and req_ready=1");
         resp_q.delete();
         bus_q.delete();
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bus_t        b;
      logic [31:0] a;
      logic [1:0]  sz;
      int          r;
      int          dly;
      reset        = 1'b1;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_size     = '0;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i]  = $urandom;
         phys_mem[i] = ref_mem[i];
      end
      ref_mem[0]  = 32'h80FF_1234;
      phys_mem[0] = 32'h80FF_1234;

      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b0;
      @(negedge clk);

      // Byte and half loads from 0x1000 = 80FF1234.
      issue(1'b0, 2'b10, 1'b0, 32'h0000_1001, 32'h0, 1, 1'b0, 1'b1, 32'hFFFF_FFFF);
      issue(1'b0, 2'b10, 1'b1, 32'h0000_1000, 32'h0, 2, 1'b1, 1'b1, 32'h0000_0080);
      issue(1'b0, 2'b01, 1'b0, 32'h0000_1002, 32'h0, 1, 1'b0, 1'b1, 32'h0000_1234);
      issue(1'b0, 2'b01, 1'b0, 32'h0000_1000, 32'h0, 3, 1'b0, 1'b1, 32'hFFFF_80FF);

      // Reset during WAIT with the ack arriving one cycle later.
      noise     = 1'b0;
      ack_delay = 2;
      spur      = 1'b0;
      b.addr = 32'h0000_1000; b.we = 1'b0; b.be = 4'b1111; b.wdata = 32'h0;
      bus_q.push_back(b);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr  = 32'h0000_1000; req_wdata = 32'h0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("mem_req_wait", {31'd0, mem_req}, 32'd1);
      reset    = 1'b1;
      late_ack = 1'b1;
      @(negedge clk);
      check_reset_vals("reset_in_wait");
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("mem_req_after_reset",   {31'd0, mem_req},   32'd0);
         chk("req_ready_after_reset", {31'd0, req_ready}, 32'd1);
      end
      noise = 1'b1;

      // Byte store then word read-back; misaligned word; ack timeout.
      issue(1'b1, 2'b10, 1'b0, 32'h0000_2003, 32'h1234_56AB, 2, 1'b0, 1'b1, 32'h0);
      issue(1'b0, 2'b00, 1'b0, 32'h0000_2000, 32'h0, 1, 1'b0, 1'b1, 32'h80FF_12AB);
      issue(1'b0, 2'b00, 1'b0, 32'h0000_3002, 32'h0, 1, 1'b0, 1'b1, 32'h0);
      issue(1'b0, 2'b00, 1'b0, 32'h0000_1008, 32'h0, 0, 1'b0, 1'b1, 32'h0);

      // Randomized traffic against the model.
      for (int n = 0; n < 250; n++) begin
         r  = $urandom_range(0, 15);
         sz = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'b00) a[1:0] = 2'b00;
            if (sz == 2'b01) a[0]   = 1'b0;
         end
         dly = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, TMO);
         issue(1'($urandom), sz, 1'($urandom), a, $urandom, dly,
               ($urandom_range(0, 3) == 0), 1'b0, 32'h0);
      end

      repeat (4) @(negedge clk);
      chk("resp_queue_empty", resp_q.size(), 32'd0);
      chk("bus_queue_empty",  bus_q.size(),  32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
